// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: fetches 8-byte lines from instruction memory and
// delivers 16-bit instructions one per accept. Handles redirects, including
// draining a request that is already in flight.
// Optional feature macro: PREFETCH_EN (adds a next-line prefetch buffer so
// sequential execution crosses line boundaries without a bubble).
module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_valid,
  input  logic [63:0] mem_line,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc
);

  typedef enum logic [1:0] {FETCH, SERVE, DRAIN} state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [63:0] line_q, line_d;
  logic [15:0] drain_addr_q, drain_addr_d;
`ifdef PREFETCH_EN
  logic [63:0] pf_line_q, pf_line_d;
  logic        pf_vld_q, pf_vld_d;
  logic        pf_req_q, pf_req_d;
`endif

  logic        mem_fire;
  logic        accept;
  logic        last_half;
  logic [15:0] half;

  // A response only counts while we are actually asking for one.
  assign mem_fire  = mem_valid && mem_req;
  assign accept    = instr_valid && instr_ready && !redirect_valid;
  assign last_half = (pc_q[2:1] == 2'd3);

  // Memory request: current line in FETCH, stale address in DRAIN,
  // next line (prefetch) in SERVE.
  always_comb begin
    mem_req  = 1'b0;
    mem_addr = {pc_q[15:3], 3'b000};
    case (state_q)
      FETCH: mem_req = 1'b1;
      DRAIN: begin
        mem_req  = 1'b1;
        mem_addr = drain_addr_q;
      end
      SERVE: begin
`ifdef PREFETCH_EN
        mem_req  = pf_req_q;
        mem_addr = {pc_q[15:3] + 13'd1, 3'b000};
`endif
      end
      default: ;
    endcase
    if (reset) mem_req = 1'b0;
  end

  // Halfword select: offset 0 lives in the top bits of the line.
  always_comb begin
    half = line_q[63:48];
    case (pc_q[2:1])
      2'd0: half = line_q[63:48];
      2'd1: half = line_q[47:32];
      2'd2: half = line_q[31:16];
      2'd3: half = line_q[15:0];
      default: ;
    endcase
  end

  assign instr_valid = (state_q == SERVE);
  assign instr       = instr_valid ? half : 16'h0000;
  assign instr_pc    = instr_valid ? pc_q : 16'h0000;

  // Next-state logic for the fetch FSM, pc and line buffers.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    line_d       = line_q;
    drain_addr_d = drain_addr_q;
`ifdef PREFETCH_EN
    pf_line_d    = pf_line_q;
    pf_vld_d     = pf_vld_q;
    pf_req_d     = pf_req_q;
`endif
    if (redirect_valid) pc_d = redirect_pc & 16'hFFFE;

    case (state_q)
      FETCH: begin
        if (redirect_valid) begin
          // Same-cycle response belongs to the old pc: drop it and refetch.
          state_d      = mem_fire ? FETCH : DRAIN;
          drain_addr_d = mem_addr;
        end else if (mem_fire) begin
          line_d  = mem_line;
          state_d = SERVE;
`ifdef PREFETCH_EN
          pf_vld_d = 1'b0;
          pf_req_d = 1'b1;
`endif
        end
      end

      DRAIN: begin
        // Further redirects only move pc; the stale response still has to land.
        if (mem_fire) state_d = FETCH;
      end

      SERVE: begin
        if (redirect_valid) begin
          // Always refetch, even if the target is inside the buffered line.
          state_d = FETCH;
`ifdef PREFETCH_EN
          pf_vld_d = 1'b0;
          pf_req_d = 1'b0;
          if (pf_req_q && !mem_fire) begin
            state_d      = DRAIN;
            drain_addr_d = mem_addr;
          end
`endif
        end else begin
`ifdef PREFETCH_EN
          if (mem_fire) begin
            pf_line_d = mem_line;
            pf_vld_d  = 1'b1;
            pf_req_d  = 1'b0;
          end
`endif
          if (accept) begin
            pc_d = pc_q + 16'd2;
            if (last_half) begin
`ifdef PREFETCH_EN
              if (pf_vld_q || mem_fire) begin
                // Next line already here: switch buffers, prefetch the one after.
                line_d   = pf_vld_q ? pf_line_q : mem_line;
                pf_vld_d = 1'b0;
                pf_req_d = 1'b1;
              end else begin
                // Prefetch still in flight for exactly this line; FETCH waits on it.
                state_d  = FETCH;
                pf_req_d = 1'b0;
              end
`else
              state_d = FETCH;
`endif
            end
          end
        end
      end

      default: state_d = FETCH;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC & 16'hFFFE;
      line_q       <= '0;
      drain_addr_q <= '0;
`ifdef PREFETCH_EN
      pf_line_q    <= '0;
      pf_vld_q     <= 1'b0;
      pf_req_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      line_q       <= line_d;
      drain_addr_q <= drain_addr_d;
`ifdef PREFETCH_EN
      pf_line_q    <= pf_line_d;
      pf_vld_q     <= pf_vld_d;
      pf_req_q     <= pf_req_d;
`endif
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a fixed-latency memory responder.
module tb_instr_fetch_unit;
  localparam logic [15:0] K = 16'hA5A5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_valid = 1'b0;
  logic [63:0] mem_line = '0;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;

  int          checks = 0;
  int          errors = 0;
  int          lat = 4;
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [15:0] raddr = '0;
  logic        spur = 1'b0;

  instr_fetch_unit #(.RESET_PC(16'h0010)) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_valid(mem_valid), .mem_line(mem_line),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  // Memory image: halfword at byte address a is a^K, except line 0x0018.
  function automatic logic [63:0] line_of(input logic [15:0] a);
    if (a == 16'h0018) return 64'h1122_3344_5566_7788;
    return {a ^ K, (a + 16'd2) ^ K, (a + 16'd4) ^ K, (a + 16'd6) ^ K};
  endfunction

  // Memory responder: answers a held request after lat cycles.
  initial begin
    forever begin
      @(negedge clk);
      mem_valid = 1'b0;
      if (spur) begin
        mem_valid = 1'b1;
        mem_line  = 64'hDEAD_BEEF_CAFE_F00D;
        spur      = 1'b0;
      end else if (reset || !mem_req) begin
        pend = 1'b0;
      end else begin
        if (!pend) begin
          pend  = 1'b1;
          cnt   = 1;
          raddr = mem_addr;
        end else begin
          cnt++;
        end
        if (cnt >= lat) begin
          mem_valid = 1'b1;
          mem_line  = line_of(raddr);
          pend      = 1'b0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!instr_valid && n < 40) begin
      tick();
      n++;
    end
    check("vld_wait", instr_valid, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [15:0] exp18 [4];
    exp18[0] = 16'h1122; exp18[1] = 16'h3344; exp18[2] = 16'h5566; exp18[3] = 16'h7788;

    // Reset state
    repeat (3) tick();
    check("rst_req",   mem_req, 1'b0);
    check("rst_vld",   instr_valid, 1'b0);
    check("rst_instr", instr, 16'h0000);
    check("rst_pc",    instr_pc, 16'h0000);

    // First cycle out of reset requests RESET_PC's line
    reset = 1'b0;
    #1;
    check("first_req",  mem_req, 1'b1);
    check("first_addr", mem_addr, 16'h0010);

    // Consecutive delivery of the first line
    wait_valid();
    for (int i = 0; i < 4; i++) begin
      check("seq_vld",   instr_valid, 1'b1);
      check("seq_pc",    instr_pc, 16'h0010 + 16'(2 * i));
      check("seq_instr", instr, (16'h0010 + 16'(2 * i)) ^ K);
      tick();
    end

`ifndef PREFETCH_EN
    // One-line bubble: fetch of next line
    check("bub_vld",  instr_valid, 1'b0);
    check("bub_req",  mem_req, 1'b1);
    check("bub_addr", mem_addr, 16'h0018);
`endif

    // Byte ordering within a line
    for (int i = 0; i < 4; i++) begin
      wait_valid();
      check("l18_pc",    instr_pc, 16'h0018 + 16'(2 * i));
      check("l18_instr", instr, exp18[i]);
      tick();
    end

`ifndef PREFETCH_EN
    // Redirect during outstanding fetch of 0x0020 -> drain
    check("f20_req",  mem_req, 1'b1);
    check("f20_addr", mem_addr, 16'h0020);
    redirect_valid = 1'b1; redirect_pc = 16'h0041;
    tick();
    redirect_valid = 1'b0;
    check("drn_addr", mem_addr, 16'h0020);
    check("drn_req",  mem_req, 1'b1);
    check("drn_vld",  instr_valid, 1'b0);
    n = 0;
    while (mem_addr !== 16'h0040 && n < 20) begin tick(); n++; end
    check("post_drn_addr", mem_addr, 16'h0040);
    wait_valid();
    check("rd_pc",    instr_pc, 16'h0040);
    check("rd_instr", instr, 16'hA5E5);

    // Redirect beats a same-cycle accept, and the same line is refetched
    redirect_valid = 1'b1; redirect_pc = 16'h0012;
    tick();
    redirect_valid = 1'b0;
    instr_ready = 1'b0;
    check("pri_vld",  instr_valid, 1'b0);
    check("pri_addr", mem_addr, 16'h0010);
    wait_valid();
    check("hold_pc0", instr_pc, 16'h0012);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_pc",    instr_pc, 16'h0012);
      check("hold_instr", instr, 16'hA5B7);
    end

    // Stray response while no request is outstanding
    spur = 1'b1;
    tick(); tick();
    check("spur_instr", instr, 16'hA5B7);
    check("spur_vld",   instr_valid, 1'b1);
    check("spur_req",   mem_req, 1'b0);
    instr_ready = 1'b1;
    tick();
    check("adv_pc", instr_pc, 16'h0014);

    // Redirect coinciding with the response in FETCH
    redirect_valid = 1'b1; redirect_pc = 16'h0100;
    tick();
    redirect_valid = 1'b0;
    n = 0;
    while (!(pend && cnt == lat - 1) && n < 20) begin tick(); n++; end
    redirect_valid = 1'b1; redirect_pc = 16'h0208;
    tick();
    redirect_valid = 1'b0;
    check("co_addr", mem_addr, 16'h0208);
    check("co_req",  mem_req, 1'b1);
    check("co_vld",  instr_valid, 1'b0);
    wait_valid();
    check("co_pc",    instr_pc, 16'h0208);
    check("co_instr", instr, 16'hA7AD);

    // Address wrap at the top of memory
    redirect_valid = 1'b1; redirect_pc = 16'hFFF8;
    tick();
    redirect_valid = 1'b0;
    wait_valid();
    for (int i = 0; i < 4; i++) begin
      check("wr_pc",    instr_pc, 16'hFFF8 + 16'(2 * i));
      check("wr_instr", instr, (16'hFFF8 + 16'(2 * i)) ^ K);
      tick();
    end
    check("wr_addr", mem_addr, 16'h0000);
    check("wr_req",  mem_req, 1'b1);
    wait_valid();
    check("wr0_pc",    instr_pc, 16'h0000);
    check("wr0_instr", instr, 16'hA5A5);

    // Reset mid-stream restarts at RESET_PC
    reset = 1'b1;
    tick();
    check("rr_req", mem_req, 1'b0);
    check("rr_vld", instr_valid, 1'b0);
    reset = 1'b0;
    #1;
    check("rr_addr", mem_addr, 16'h0010);
    wait_valid();
    check("rr_pc", instr_pc, 16'h0010);
`else
    // Prefetch: no bubble across lines
    lat = 2;
    redirect_valid = 1'b1; redirect_pc = 16'h0080;
    tick();
    redirect_valid = 1'b0;
    wait_valid();
    for (int i = 0; i < 8; i++) begin
      check("pf_vld",   instr_valid, 1'b1);
      check("pf_pc",    instr_pc, 16'h0080 + 16'(2 * i));
      check("pf_instr", instr, (16'h0080 + 16'(2 * i)) ^ K);
      tick();
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
